// File: rtl/neuron_feeder.sv
// neuron_feeder: sequencer that feeds a neuron_Nbits instance from two small
// register files. A run clears the neuron's accumulator for one cycle, streams
// n (W,X) pairs with en high, waits for the neuron's registered output, then
// captures that output into result and pulses done.
//
// Observable timeline, where edge 0 is the edge that samples start:
//   after edge 0            : busy=1 (state CLEAR)
//   after edge 1            : nrn_rst_n=0, en=0 (accumulator clear)
//   after edges 2..n+1      : en=1, (W,X) = (wfile[k], xfile[k]), k=0..n-1
//   after edges n+2..n+1+WC : en=0, W/X hold the last pair
//   after edge n+2+WC       : done=1, busy=0, result=nrn_out
module neuron_feeder #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AW       = $clog2(DEPTH),
    parameter int WAIT_CYC = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic                    wr_sel,
    input  logic [AW-1:0]           wr_addr,
    input  logic signed [WIDTH-1:0] wr_data,
    input  logic [AW:0]             len,
    input  logic                    start,
    output logic signed [WIDTH-1:0] W,
    output logic signed [WIDTH-1:0] X,
    output logic                    en,
    output logic                    nrn_rst_n,
    input  logic signed [WIDTH-1:0] nrn_out,
    output logic                    busy,
    output logic                    done,
    output logic signed [WIDTH-1:0] result
);

    // Vector length limit expressed in the width of len.
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    // Wait counter wide enough to hold WAIT_CYC itself.
    localparam int              WCW    = $clog2(WAIT_CYC + 1) + 1;
    localparam logic [WCW-1:0]  WAIT_L = WCW'(WAIT_CYC);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        STREAM,
        WAIT
    } state_t;

    state_t            state;
    logic [AW-1:0]     idx;
    logic [AW:0]       n;
    logic [WCW-1:0]    wcnt;
    logic              last_pair;
    logic              wr_ok;

    // Register files: contents survive reset, only the sequencer is reset.
    logic signed [WIDTH-1:0] wfile [DEPTH];
    logic signed [WIDTH-1:0] xfile [DEPTH];

    // Writes are accepted only while idle and only to existing entries.
    assign wr_ok = wr_en && !busy && ({1'b0, wr_addr} < DEPTH_L);

    // The cycle that streams entry n-1 ends the STREAM phase.
    assign last_pair = ({1'b0, idx} == (n - 1'b1));

    // Weight register file write port.
    always_ff @(posedge clk) begin
        if (wr_ok && !wr_sel) begin
            wfile[wr_addr] <= wr_data;
        end
    end

    // Input register file write port.
    always_ff @(posedge clk) begin
        if (wr_ok && wr_sel) begin
            xfile[wr_addr] <= wr_data;
        end
    end

    // Sequencer FSM with all neuron-facing and status outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            n         <= '0;
            wcnt      <= '0;
            W         <= '0;
            X         <= '0;
            en        <= 1'b0;
            nrn_rst_n <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    en        <= 1'b0;
                    nrn_rst_n <= 1'b1;
                    if (start) begin
                        if (len == '0) begin
                            // Empty vector: report completion, leave result alone.
                            done <= 1'b1;
                        end else begin
                            n     <= (len > DEPTH_L) ? DEPTH_L : len;
                            idx   <= '0;
                            busy  <= 1'b1;
                            state <= CLEAR;
                        end
                    end
                end

                CLEAR: begin
                    en        <= 1'b0;
                    nrn_rst_n <= 1'b0;
                    wcnt      <= '0;
                    state     <= STREAM;
                end

                STREAM: begin
                    nrn_rst_n <= 1'b1;
                    en        <= 1'b1;
                    W         <= wfile[idx];
                    X         <= xfile[idx];
                    if (last_pair) begin
                        state <= WAIT;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end

                WAIT: begin
                    // WAIT_CYC idle cycles let the neuron's output settle,
                    // the following edge captures it.
                    en <= 1'b0;
                    if (wcnt == WAIT_L) begin
                        result <= nrn_out;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_feeder.sv
// Testbench for neuron_feeder: randomized register-file contents and lengths,
// checked against a reference built from array copies of the files and the
// documented run timeline. The neuron is replaced by a stub nrn_out value
// that only becomes the expected value just before the capture edge.
module tb_neuron_feeder;

    localparam int WIDTH    = 8;
    localparam int DEPTH    = 16;
    localparam int AW       = 4;
    localparam int WAIT_CYC = 1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    wr_en;
    logic                    wr_sel;
    logic [AW-1:0]           wr_addr;
    logic signed [WIDTH-1:0] wr_data;
    logic [AW:0]             len;
    logic                    start;
    logic signed [WIDTH-1:0] W;
    logic signed [WIDTH-1:0] X;
    logic                    en;
    logic                    nrn_rst_n;
    logic signed [WIDTH-1:0] nrn_out;
    logic                    busy;
    logic                    done;
    logic signed [WIDTH-1:0] result;

    int total = 0;
    int bad   = 0;

    // Reference copies of the register files and the expected result register.
    logic signed [WIDTH-1:0] wref [DEPTH];
    logic signed [WIDTH-1:0] xref [DEPTH];
    logic signed [WIDTH-1:0] result_ref;

    always #5 clk = ~clk;

    neuron_feeder #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AW       (AW),
        .WAIT_CYC (WAIT_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .len       (len),
        .start     (start),
        .W         (W),
        .X         (X),
        .en        (en),
        .nrn_rst_n (nrn_rst_n),
        .nrn_out   (nrn_out),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    // One idle-time write; called and returns at a negedge.
    task automatic wr(input logic sel, input int addr, input logic signed [WIDTH-1:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = AW'(addr);
        wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
        if (sel) xref[addr] = data;
        else     wref[addr] = data;
        $display("write sel=%0d addr=%0d data=%0d", sel, addr, data);
    endtask

    // One run of the sequencer, checked against the timeline and file model.
    // poke: raise start and a write to wfile[0] while busy (both must be ignored).
    // b2b: return at the done cycle so the caller can start again immediately.
    task automatic run_seq(input int len_in, input bit poke, input bit b2b);
        int n, cyc, done_at, clr_cnt, clr_at, en_cnt, first_en, budget;
        bit busy_at_done;
        logic signed [WIDTH-1:0] got_w[$];
        logic signed [WIDTH-1:0] got_x[$];
        logic signed [WIDTH-1:0] final_val, res_seen, w_at_done, x_at_done;

        n         = (len_in > DEPTH) ? DEPTH : len_in;
        final_val = WIDTH'($urandom);
        nrn_out   = final_val ^ 8'sh5A;
        done_at   = -1;
        clr_cnt   = 0;
        clr_at    = -1;
        en_cnt    = 0;
        first_en  = -1;
        busy_at_done = 1'b1;
        res_seen  = '0;
        w_at_done = '0;
        x_at_done = '0;
        budget    = n + WAIT_CYC + 10;

        start = 1'b1;
        len   = (AW + 1)'(len_in);
        @(negedge clk);
        start = 1'b0;
        for (cyc = 0; cyc < budget; cyc++) begin
            if (en) begin
                if (first_en < 0) first_en = cyc;
                en_cnt++;
                got_w.push_back(W);
                got_x.push_back(X);
            end
            if (!nrn_rst_n) begin
                if (clr_at < 0) clr_at = cyc;
                clr_cnt++;
            end
            if (done) begin
                done_at      = cyc;
                busy_at_done = busy;
                res_seen     = result;
                w_at_done    = W;
                x_at_done    = X;
                break;
            end
            if (n > 0 && cyc == n + 1 + WAIT_CYC) nrn_out = final_val;
            if (poke && cyc == 2) begin
                start = 1'b1; len = 5'd3;
                wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = 8'sd99;
            end
            if (poke && cyc == 3) begin
                start = 1'b0;
                wr_en = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        wr_en = 1'b0;
        if (n > 0) result_ref = final_val;

        total++;
        if (done_at !== ((n == 0) ? 0 : n + 2 + WAIT_CYC)) begin
            bad++;
            $display("FAIL done_latency len=%0d: got cycle %0d, expected %0d", len_in, done_at,
                     (n == 0) ? 0 : n + 2 + WAIT_CYC);
        end
        total++;
        if (en_cnt !== n) begin
            bad++;
            $display("FAIL en_count len=%0d: got %0d, expected %0d", len_in, en_cnt, n);
        end
        total++;
        if (clr_cnt !== ((n == 0) ? 0 : 1)) begin
            bad++;
            $display("FAIL clear_count len=%0d: got %0d, expected %0d", len_in, clr_cnt, (n == 0) ? 0 : 1);
        end
        if (n > 0) begin
            total++;
            if (clr_at !== 1 || first_en !== 2) begin
                bad++;
                $display("FAIL phase_start len=%0d: clear at %0d en at %0d, expected 1 and 2",
                         len_in, clr_at, first_en);
            end
            for (int i = 0; i < n && i < en_cnt; i++) begin
                total++;
                if (got_w[i] !== wref[i] || got_x[i] !== xref[i]) begin
                    bad++;
                    $display("FAIL pair[%0d]: got (%0d,%0d), expected (%0d,%0d)",
                             i, got_w[i], got_x[i], wref[i], xref[i]);
                end
            end
            total++;
            if (w_at_done !== wref[n-1] || x_at_done !== xref[n-1]) begin
                bad++;
                $display("FAIL hold_pair: got (%0d,%0d), expected (%0d,%0d)",
                         w_at_done, x_at_done, wref[n-1], xref[n-1]);
            end
        end
        total++;
        if (res_seen !== result_ref) begin
            bad++;
            $display("FAIL result len=%0d: got %0d, expected %0d", len_in, res_seen, result_ref);
        end
        total++;
        if (busy_at_done !== 1'b0) begin
            bad++;
            $display("FAIL busy_at_done: got %0d, expected 0", busy_at_done);
        end
        if (!b2b && done_at >= 0) begin
            @(negedge clk);
            total++;
            if (done !== 1'b0 || busy !== 1'b0 || en !== 1'b0) begin
                bad++;
                $display("FAIL after_done: done=%0d busy=%0d en=%0d, expected all 0", done, busy, en);
            end
        end
        $display("run len=%0d n=%0d done_cycle=%0d pairs=%0d result=%0d poke=%0d",
                 len_in, n, done_at, en_cnt, res_seen, poke);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        total++;
        if (W !== '0 || X !== '0 || en !== 1'b0 || nrn_rst_n !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
            bad++;
            $display("FAIL reset_values: W=%0d X=%0d en=%0d nrn_rst_n=%0d busy=%0d done=%0d result=%0d, expected 0s",
                     W, X, en, nrn_rst_n, busy, done, result);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (nrn_rst_n !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: nrn_rst_n=%0d busy=%0d, expected 1 and 0", nrn_rst_n, busy);
        end
        result_ref = '0;
        $display("reset checked");
    endtask

    task automatic test_directed();
        wr(1'b0, 0, -8'sd3);
        wr(1'b0, 1, 8'sd5);
        wr(1'b1, 0, 8'sd2);
        wr(1'b1, 1, -8'sd4);
        run_seq(2, 1'b0, 1'b0);
        wr(1'b0, 0, 8'sd64);
        wr(1'b0, 1, 8'sd64);
        wr(1'b1, 0, 8'sd2);
        wr(1'b1, 1, 8'sd2);
        run_seq(2, 1'b0, 1'b0);
    endtask

    task automatic test_busy_ignore();
        // start and a wfile write issued mid-run; the next run must show neither.
        run_seq(1, 1'b1, 1'b0);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_start_queued: busy=%0d, expected 0", busy);
        end
        run_seq(1, 1'b0, 1'b0);
    endtask

    task automatic test_len_edges();
        run_seq(0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            wr(1'b0, i, WIDTH'($urandom));
            wr(1'b1, i, WIDTH'($urandom));
        end
        run_seq(20, 1'b0, 1'b0);
        run_seq(DEPTH, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        int cyc;
        bit seen_done;
        start = 1'b1;
        len   = 5'd4;
        @(negedge clk);
        start = 1'b0;
        for (cyc = 0; cyc < 3; cyc++) @(negedge clk);
        // Now after edge 3: second streamed pair is on the outputs.
        total++;
        if (en !== 1'b1) begin
            bad++;
            $display("FAIL abort_setup: en=%0d, expected 1", en);
        end
        rst = 1'b1;
        #1;
        total++;
        if (W !== '0 || X !== '0 || en !== 1'b0 || nrn_rst_n !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort_values: W=%0d X=%0d en=%0d nrn_rst_n=%0d busy=%0d done=%0d, expected 0s",
                     W, X, en, nrn_rst_n, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        for (cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (done || en || busy) seen_done = 1'b1;
        end
        total++;
        if (seen_done !== 1'b0) begin
            bad++;
            $display("FAIL abort_quiet: activity after abort, expected none");
        end
        result_ref = '0;
        $display("abort checked");
        run_seq(4, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_seq(3, 1'b0, 1'b1);
        run_seq(0, 1'b0, 1'b1);
        run_seq(2, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 4; k++) begin
                wr(1'($urandom), int'($urandom_range(0, DEPTH - 1)), WIDTH'($urandom));
            end
            run_seq(int'($urandom_range(0, 20)), 1'b0, 1'($urandom_range(0, 1)));
        end
        @(negedge clk);
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_sel  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        len     = '0;
        start   = 1'b0;
        nrn_out = '0;
        result_ref = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wref[i] = '0;
            xref[i] = '0;
        end
        @(negedge clk);
        test_reset();
        for (int i = 0; i < DEPTH; i++) begin
            wr(1'b0, i, '0);
            wr(1'b1, i, '0);
        end
        test_directed();
        test_busy_ignore();
        test_len_edges();
        test_abort();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
